// File: rtl/rand_scheduler_if.sv
// rand_scheduler_if
// Bundles the request/grant and random-delivery signals of rand_scheduler.
//   req        requester request levels (held until the matching ack)
//   seed_load  one-cycle pulse reloading the LFSR
//   seed       seed value sampled with seed_load
//   ack        one-hot, one-cycle grant pulse
//   rnd_out    delivered random byte, valid while rnd_valid is high
//   rnd_valid  high during the grant cycle only
//   ready      high while the scheduler waits in READY
//   grant_cnt  running count of grants since reset (wraps)
// The master modport is the requester side, the slave modport the scheduler.
interface rand_scheduler_if #(
   parameter int N_REQ = 4
);
   logic [N_REQ-1:0] req;
   logic             seed_load;
   logic [7:0]       seed;
   logic [N_REQ-1:0] ack;
   logic [7:0]       rnd_out;
   logic             rnd_valid;
   logic             ready;
   logic [15:0]      grant_cnt;

   modport master (
      output req, seed_load, seed,
      input  ack, rnd_out, rnd_valid, ready, grant_cnt
   );

   modport slave (
      input  req, seed_load, seed,
      output ack, rnd_out, rnd_valid, ready, grant_cnt
   );
endinterface

// File: rtl/rand_scheduler.sv
// rand_scheduler
// Shares one 8-bit Fibonacci LFSR between N_REQ requesters. A value is only
// handed out after the LFSR has shifted at least MIN_SHIFTS times since the
// previous delivery (or reseed), and requesters are served round-robin.
// Ports:
//   clock  system clock, rising edge
//   reset  asynchronous active-high reset
//   bus    rand_scheduler_if slave modport (req/seed_load/seed in,
//          ack/rnd_out/rnd_valid/ready/grant_cnt out)
// SEED must be nonzero, otherwise the LFSR locks up at zero.
module rand_scheduler #(
   parameter int         N_REQ      = 4,
   parameter int         MIN_SHIFTS = 8,
   parameter logic [7:0] SEED       = 8'h0F
) (
   input logic            clock,
   input logic            reset,
   rand_scheduler_if.slave bus
);

   localparam int FW = $clog2(MIN_SHIFTS + 1);
   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   localparam logic [1:0] WAIT  = 2'd0;
   localparam logic [1:0] READY = 2'd1;
   localparam logic [1:0] GRANT = 2'd2;

   logic [1:0]       state_q,     state_d;
   logic [7:0]       lfsr_q,      lfsr_d;
   logic [FW-1:0]    fresh_q,     fresh_d;
   logic [PW-1:0]    ptr_q,       ptr_d;
   logic [N_REQ-1:0] ack_q,       ack_d;
   logic [7:0]       rnd_out_q,   rnd_out_d;
   logic             rnd_valid_q, rnd_valid_d;
   logic [15:0]      grant_cnt_q, grant_cnt_d;

   logic             grantNow;
   logic             winnerFound;
   logic [PW-1:0]    winnerIdx;
   logic [PW-1:0]    candIdx;
   int               candSum;

   // Round-robin search: walk upward from ptr_q with wrap and take the
   // first active request.
   always_comb begin : arbiter
      winnerFound = 1'b0;
      winnerIdx   = '0;
      candIdx     = '0;
      candSum     = 0;
      for (int k = 0; k < N_REQ; k++) begin
         candSum = int'(ptr_q) + k;
         if (candSum >= N_REQ) begin
            candSum = candSum - N_REQ;
         end
         candIdx = PW'(candSum);
         if (!winnerFound && bus.req[candIdx]) begin
            winnerFound = 1'b1;
            winnerIdx   = candIdx;
         end
      end
   end

   // Next-state logic. A reseed wins over a pending grant, and the freshness
   // counter restarts whenever a value is consumed or the LFSR is reloaded.
   always_comb begin : nextState
      grantNow = (state_q == READY) && (|bus.req) && !bus.seed_load;

      if (bus.seed_load || grantNow) begin
         fresh_d = '0;
      end else if (fresh_q == FW'(MIN_SHIFTS)) begin
         fresh_d = fresh_q;
      end else begin
         fresh_d = fresh_q + FW'(1);
      end

      state_d = state_q;
      if (bus.seed_load) begin
         state_d = WAIT;
      end else begin
         case (state_q)
            WAIT:    if (fresh_d == FW'(MIN_SHIFTS)) state_d = READY;
            READY:   if (grantNow) state_d = GRANT;
            GRANT:   state_d = WAIT;
            default: state_d = WAIT;
         endcase
      end

      if (bus.seed_load) begin
         lfsr_d = (bus.seed == 8'h00) ? SEED : bus.seed;
      end else begin
         lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      end

      ptr_d       = ptr_q;
      ack_d       = '0;
      rnd_valid_d = 1'b0;
      rnd_out_d   = rnd_out_q;
      grant_cnt_d = grant_cnt_q;
      if (grantNow) begin
         ptr_d       = (winnerIdx == PW'(N_REQ - 1)) ? '0 : winnerIdx + PW'(1);
         ack_d       = N_REQ'(1) << winnerIdx;
         rnd_valid_d = 1'b1;
         rnd_out_d   = lfsr_q;
         grant_cnt_d = grant_cnt_q + 16'd1;
      end
   end

   // State registers; reset also kills an in-flight grant pulse at once.
   always_ff @(posedge clock or posedge reset) begin : regs
      if (reset) begin
         state_q     <= WAIT;
         lfsr_q      <= SEED;
         fresh_q     <= '0;
         ptr_q       <= '0;
         ack_q       <= '0;
         rnd_out_q   <= 8'h00;
         rnd_valid_q <= 1'b0;
         grant_cnt_q <= 16'h0000;
      end else begin
         state_q     <= state_d;
         lfsr_q      <= lfsr_d;
         fresh_q     <= fresh_d;
         ptr_q       <= ptr_d;
         ack_q       <= ack_d;
         rnd_out_q   <= rnd_out_d;
         rnd_valid_q <= rnd_valid_d;
         grant_cnt_q <= grant_cnt_d;
      end
   end

   assign bus.ack       = ack_q;
   assign bus.rnd_out   = rnd_out_q;
   assign bus.rnd_valid = rnd_valid_q;
   assign bus.ready     = (state_q == READY);
   assign bus.grant_cnt = grant_cnt_q;

endmodule

// File: tb/tb_rand_scheduler.sv
// tb_rand_scheduler
// Self-checking bench for rand_scheduler: directed scenarios followed by a
// randomized run, all compared cycle by cycle against a behavioural model.
module tb_rand_scheduler;

   localparam int         NREQ = 4;
   localparam int         MINS = 8;
   localparam logic [7:0] SEED = 8'h0F;

   localparam int S_WAIT  = 0;
   localparam int S_READY = 1;
   localparam int S_GRANT = 2;

   logic clock = 1'b0;
   logic reset = 1'b1;

   rand_scheduler_if #(.N_REQ(NREQ)) bus ();

   rand_scheduler #(.N_REQ(NREQ), .MIN_SHIFTS(MINS), .SEED(SEED)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // Behavioural model state
   int         mState;
   int         mLfsr;
   int         mFresh;
   int         mPtr;
   int         mCnt;
   logic [3:0] mAck;
   logic [7:0] mRnd;
   logic       mValid;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] r, input logic sl, input logic [7:0] s);
      bus.req       = r;
      bus.seed_load = sl;
      bus.seed      = s;
   endtask

   task automatic modelReset();
      mState = S_WAIT;
      mLfsr  = int'(SEED);
      mFresh = 0;
      mPtr   = 0;
      mCnt   = 0;
      mAck   = '0;
      mRnd   = 8'h00;
      mValid = 1'b0;
   endtask

   // One clock edge of the scheduler's rules, evaluated on the inputs that
   // are stable in front of the edge.
   task automatic modelStep();
      bit grantNow;
      int w;
      grantNow = (mState == S_READY) && (bus.req != 0) && !bus.seed_load;
      mAck   = '0;
      mValid = 1'b0;
      if (grantNow) begin
         w = -1;
         for (int k = 0; k < NREQ; k++) begin
            if (w < 0 && bus.req[(mPtr + k) % NREQ]) w = (mPtr + k) % NREQ;
         end
         mAck   = 4'(1 << w);
         mValid = 1'b1;
         mRnd   = 8'(mLfsr);
         mPtr   = (w + 1) % NREQ;
         mCnt   = (mCnt + 1) % 65536;
      end
      if (bus.seed_load || grantNow) mFresh = 0;
      else if (mFresh < MINS) mFresh = mFresh + 1;
      if (bus.seed_load) mState = S_WAIT;
      else if (mState == S_WAIT) begin
         if (mFresh == MINS) mState = S_READY;
      end else if (mState == S_READY) begin
         if (grantNow) mState = S_GRANT;
      end else mState = S_WAIT;
      if (bus.seed_load) mLfsr = (bus.seed == 8'h00) ? int'(SEED) : int'(bus.seed);
      else mLfsr = ((mLfsr << 1) | ($countones(mLfsr & 'hB8) & 1)) & 'hFF;
   endtask

   task automatic compareModel(input string tag);
      checkOutput({tag, ".ack"},       32'(bus.ack),       32'(mAck));
      checkOutput({tag, ".rnd_valid"}, 32'(bus.rnd_valid), 32'(mValid));
      checkOutput({tag, ".rnd_out"},   32'(bus.rnd_out),   32'(mRnd));
      checkOutput({tag, ".ready"},     32'(bus.ready),     32'(mState == S_READY));
      checkOutput({tag, ".grant_cnt"}, 32'(bus.grant_cnt), 32'(mCnt));
      checkOutput({tag, ".lfsr"},      32'(dut.lfsr_q),    32'(mLfsr));
   endtask

   task automatic cycle(input string tag);
      modelStep();
      @(posedge clock);
      @(negedge clock);
      compareModel(tag);
   endtask

   task automatic doReset();
      reset = 1'b1;
      applyStimulus(4'b0000, 1'b0, 8'h00);
      modelReset();
      @(negedge clock);
      compareModel("reset");
      reset = 1'b0;
   endtask

   task automatic waitAck(input int limit, output int n);
      n = 0;
      while (bus.ack == '0 && n < limit) begin
         cycle("waitAck");
         n++;
      end
      checkOutput("ackWithinBound", 32'(n < limit), 32'd1);
   endtask

   logic [7:0] lfsrSeq [9] = '{8'h1F, 8'h3E, 8'h7D, 8'hFB, 8'hF6, 8'hED, 8'hDB, 8'hB7, 8'h6F};
   int         grantIdx [$];
   int         grantAt [$];
   int         n;

   initial begin
      applyStimulus(4'b0000, 1'b0, 8'h00);

      // Reset values
      doReset();
      checkOutput("resetAck",      32'(bus.ack),       32'd0);
      checkOutput("resetRndOut",   32'(bus.rnd_out),   32'h00);
      checkOutput("resetValid",    32'(bus.rnd_valid), 32'd0);
      checkOutput("resetReady",    32'(bus.ready),     32'd0);
      checkOutput("resetGrantCnt", 32'(bus.grant_cnt), 32'd0);

      // LFSR sequence after reset release, ready rising after e8
      for (int i = 0; i < 9; i++) begin
         cycle("lfsrSeq");
         checkOutput("lfsrSeqValue", 32'(dut.lfsr_q), 32'(lfsrSeq[i]));
         checkOutput("lfsrSeqReady", 32'(bus.ready), 32'(i >= 7));
      end

      // First grant with req[2] held from reset
      doReset();
      applyStimulus(4'b0100, 1'b0, 8'h00);
      repeat (9) cycle("firstGrant");
      checkOutput("firstAck",      32'(bus.ack),       32'h4);
      checkOutput("firstRnd",      32'(bus.rnd_out),   32'hB7);
      checkOutput("firstValid",    32'(bus.rnd_valid), 32'd1);
      checkOutput("firstGrantCnt", 32'(bus.grant_cnt), 32'd1);
      cycle("afterFirst");
      checkOutput("afterFirstAck",   32'(bus.ack),       32'd0);
      checkOutput("afterFirstValid", 32'(bus.rnd_valid), 32'd0);
      checkOutput("afterFirstRnd",   32'(bus.rnd_out),   32'hB7);

      // Round-robin with all requests held
      doReset();
      applyStimulus(4'b1111, 1'b0, 8'h00);
      for (int c = 1; c <= 40; c++) begin
         cycle("roundRobin");
         if (bus.ack != '0) begin
            grantIdx.push_back($clog2(bus.ack));
            grantAt.push_back(c);
         end
      end
      checkOutput("rrGrantCount", 32'(grantIdx.size()), 32'd4);
      for (int i = 0; i < grantIdx.size() && i < 4; i++) begin
         checkOutput("rrOrder", 32'(grantIdx[i]), 32'(i));
         checkOutput("rrCycle", 32'(grantAt[i]), 32'(9 * (i + 1)));
      end
      checkOutput("rrGrantCnt", 32'(bus.grant_cnt), 32'd4);

      // Reseed with zero while READY and a request pending
      doReset();
      repeat (8) cycle("toReady");
      checkOutput("seedPreReady", 32'(bus.ready), 32'd1);
      applyStimulus(4'b0001, 1'b1, 8'h00);
      cycle("seedZero");
      checkOutput("seedNoAck", 32'(bus.ack), 32'd0);
      checkOutput("seedLfsr",  32'(dut.lfsr_q), 32'h0F);
      checkOutput("seedWait",  32'(bus.ready), 32'd0);
      applyStimulus(4'b0001, 1'b0, 8'h00);
      waitAck(30, n);
      checkOutput("seedAckDelay", 32'(n + 1), 32'd10);
      checkOutput("seedAckCycles", 32'(n), 32'd9);

      // Request withdrawn before READY: no ack, pointer untouched
      doReset();
      applyStimulus(4'b0010, 1'b0, 8'h00);
      repeat (3) cycle("dropReq");
      applyStimulus(4'b0000, 1'b0, 8'h00);
      for (int i = 0; i < 10; i++) begin
         cycle("dropIdle");
         checkOutput("dropNoAck", 32'(bus.ack), 32'd0);
      end
      applyStimulus(4'b1111, 1'b0, 8'h00);
      cycle("dropAll");
      checkOutput("dropPtrKept", 32'(bus.ack), 32'h1);

      // grant_cnt wrap from 16'hFFFF
      applyStimulus(4'b0000, 1'b0, 8'h00);
      repeat (9) cycle("wrapIdle");
      force dut.grant_cnt_q = 16'hFFFF;
      mCnt = 16'hFFFF;
      cycle("wrapForced");
      cycle("wrapForced");
      release dut.grant_cnt_q;
      checkOutput("wrapPre", 32'(bus.grant_cnt), 32'hFFFF);
      applyStimulus(4'b0001, 1'b0, 8'h00);
      cycle("wrapGrant");
      checkOutput("wrapAck", 32'(bus.ack), 32'h1);
      checkOutput("wrapCnt", 32'(bus.grant_cnt), 32'h0000);

      // Reset in the middle of GRANT
      waitAck(20, n);
      reset = 1'b1;
      #1;
      checkOutput("midResetAck",   32'(bus.ack),       32'd0);
      checkOutput("midResetValid", 32'(bus.rnd_valid), 32'd0);
      checkOutput("midResetCnt",   32'(bus.grant_cnt), 32'd0);
      doReset();

      // Reseed during the GRANT cycle: the ack completes, then WAIT
      applyStimulus(4'b0100, 1'b0, 8'h00);
      waitAck(20, n);
      checkOutput("grantSeedAck", 32'(bus.ack), 32'h4);
      applyStimulus(4'b0100, 1'b1, 8'h5A);
      cycle("grantSeed");
      checkOutput("grantSeedLfsr",  32'(dut.lfsr_q), 32'h5A);
      checkOutput("grantSeedReady", 32'(bus.ready), 32'd0);
      checkOutput("grantSeedNoAck", 32'(bus.ack), 32'd0);

      // Randomized run against the model
      doReset();
      for (int i = 0; i < 400; i++) begin
         applyStimulus(4'($urandom_range(0, 15)),
                       ($urandom_range(0, 19) == 0),
                       ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255)));
         cycle("random");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
